// File: rtl/seq_gen_detect_if.sv
// =============================================================================
// Module   : seq_gen_detect_if
// Purpose  : Control/status bundle between the board top and seq_gen_detect.
//            Extra seq_in/ext_sel signals exist only when SEQ_EXT_IN_EN is set.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface seq_gen_detect_if #(
    parameter int GEN_LEN = 16,
    parameter int DET_LEN = 5,
    parameter int CNT_W   = 8
);
    logic               tick;
    logic               enable;
    logic               load;
    logic [GEN_LEN-1:0] gen_pattern;
    logic [DET_LEN-1:0] det_pattern;
    logic               overlap;
    logic               clear_cnt;
    logic               seq_out;
    logic [DET_LEN-1:0] det_window;
    logic               match;
    logic               match_led;
    logic [CNT_W-1:0]   match_cnt;
`ifdef SEQ_EXT_IN_EN
    logic               seq_in;
    logic               ext_sel;

    modport master (
        output tick, enable, load, gen_pattern, det_pattern, overlap, clear_cnt,
               seq_in, ext_sel,
        input  seq_out, det_window, match, match_led, match_cnt
    );
    modport slave (
        input  tick, enable, load, gen_pattern, det_pattern, overlap, clear_cnt,
               seq_in, ext_sel,
        output seq_out, det_window, match, match_led, match_cnt
    );
`else
    modport master (
        output tick, enable, load, gen_pattern, det_pattern, overlap, clear_cnt,
        input  seq_out, det_window, match, match_led, match_cnt
    );
    modport slave (
        input  tick, enable, load, gen_pattern, det_pattern, overlap, clear_cnt,
        output seq_out, det_window, match, match_led, match_cnt
    );
`endif
endinterface

`default_nettype wire

// File: rtl/seq_gen_detect.sv
// =============================================================================
// Module   : seq_gen_detect
// Purpose  : Tick-paced MSB-first pattern generator with a sliding-window
//            detector, saturating match counter and LED drivers.
//            Optional macro SEQ_EXT_IN_EN: detector can be fed from seq_in.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_gen_detect #(
    parameter int                 GEN_LEN  = 16,
    parameter logic [GEN_LEN-1:0] GEN_INIT = 16'h74DA,
    parameter int                 DET_LEN  = 5,
    parameter logic [DET_LEN-1:0] DET_INIT = 5'b11010,
    parameter int                 CNT_W    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seq_gen_detect_if.slave   bus
);

    localparam int                  C_PTR_W     = (GEN_LEN > 1) ? $clog2(GEN_LEN) : 1;
    localparam int                  C_FILL_W    = $clog2(DET_LEN + 1);
    localparam logic [C_PTR_W-1:0]  C_PTR_TOP   = C_PTR_W'(GEN_LEN - 1);
    localparam logic [C_PTR_W-1:0]  C_PTR_ONE   = C_PTR_W'(1);
    localparam logic [C_FILL_W-1:0] C_FILL_FULL = C_FILL_W'(DET_LEN);
    localparam logic [C_FILL_W-1:0] C_FILL_ONE  = C_FILL_W'(1);
    localparam logic [CNT_W-1:0]    C_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    C_CNT_ONE   = CNT_W'(1);

    logic [GEN_LEN-1:0]  r_gen;
    logic [DET_LEN-1:0]  r_det;
    logic [C_PTR_W-1:0]  r_ptr;
    logic [C_FILL_W-1:0] r_fill;
    logic                r_seq_out;
    logic [DET_LEN-1:0]  r_window;
    logic                r_match;
    logic                r_match_led;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_step;
    logic                w_gen_bit;
    logic                w_det_bit;
    logic [DET_LEN-1:0]  w_window_nx;
    logic [C_FILL_W-1:0] w_fill_nx;
    logic                w_hit;

    // load has priority over a step in the same cycle
    assign w_step    = bus.enable & bus.tick & ~bus.load;
    assign w_gen_bit = r_gen[r_ptr];
`ifdef SEQ_EXT_IN_EN
    assign w_det_bit = bus.ext_sel ? bus.seq_in : w_gen_bit;
`else
    assign w_det_bit = w_gen_bit;
`endif
    assign w_window_nx = {r_window[DET_LEN-2:0], w_det_bit};
    assign w_fill_nx   = (r_fill == C_FILL_FULL) ? C_FILL_FULL : r_fill + C_FILL_ONE;
    // Match looks at the post-step window so it lines up with det_window
    assign w_hit       = (w_fill_nx == C_FILL_FULL) && (w_window_nx == r_det);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen       <= GEN_INIT;
            r_det       <= DET_INIT;
            r_ptr       <= C_PTR_TOP;
            r_fill      <= '0;
            r_seq_out   <= 1'b0;
            r_window    <= '0;
            r_match     <= 1'b0;
            r_match_led <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_match <= 1'b0;
            if (bus.load) begin
                r_gen       <= bus.gen_pattern;
                r_det       <= bus.det_pattern;
                r_ptr       <= C_PTR_TOP;
                r_fill      <= '0;
                r_window    <= '0;
                r_seq_out   <= 1'b0;
                r_match_led <= 1'b0;
            end else if (w_step) begin
                r_seq_out   <= w_gen_bit;
                r_window    <= w_window_nx;
                r_ptr       <= (r_ptr == '0) ? C_PTR_TOP : r_ptr - C_PTR_ONE;
                // Non-overlapping mode demands DET_LEN fresh bits after a hit
                r_fill      <= (w_hit && !bus.overlap) ? '0 : w_fill_nx;
                r_match     <= w_hit;
                r_match_led <= w_hit;
            end

            if (bus.clear_cnt) begin
                r_cnt <= '0;
            end else if (w_step && w_hit && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.seq_out    = r_seq_out;
    assign bus.det_window = r_window;
    assign bus.match      = r_match;
    assign bus.match_led  = r_match_led;
    assign bus.match_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_detect.sv
// =============================================================================
// Module   : tb_seq_gen_detect
// Purpose  : Self-checking bench for seq_gen_detect (default and CNT_W=2 DUTs).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_seq_gen_detect;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_gen_detect_if #(.GEN_LEN(16), .DET_LEN(5), .CNT_W(8)) bus ();
    seq_gen_detect_if #(.GEN_LEN(16), .DET_LEN(5), .CNT_W(2)) bus2 ();

    assign bus2.tick        = bus.tick;
    assign bus2.enable      = bus.enable;
    assign bus2.load        = bus.load;
    assign bus2.gen_pattern = bus.gen_pattern;
    assign bus2.det_pattern = bus.det_pattern;
    assign bus2.overlap     = bus.overlap;
    assign bus2.clear_cnt   = bus.clear_cnt;
`ifdef SEQ_EXT_IN_EN
    assign bus2.seq_in      = bus.seq_in;
    assign bus2.ext_sel     = bus.ext_sel;
`endif

    seq_gen_detect dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_gen_detect #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bit history plus "bits since last restart" counter
    logic [15:0] m_gen;
    logic [4:0]  m_det;
    int          m_idx;
    bit          hist[$];
    int          m_since;
    logic        m_seq, m_match, m_led;
    int          m_cnt, m_cnt2;

    function automatic logic [4:0] m_window();
        logic [4:0] w = '0;
        foreach (hist[i]) w = {w[3:0], hist[i]};
        return w;
    endfunction

    task automatic m_reset();
        m_gen = 16'h74DA; m_det = 5'b11010; m_idx = 0; hist.delete();
        m_since = 0; m_seq = 0; m_match = 0; m_led = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic m_apply(input logic t, input logic e, input logic l, input logic c);
        logic hit = 1'b0;
        logic b;
        m_match = 1'b0;
        if (l) begin
            m_gen = bus.gen_pattern; m_det = bus.det_pattern; m_idx = 0;
            hist.delete(); m_since = 0; m_seq = 0; m_led = 0;
        end else if (t && e) begin
            m_seq = m_gen[15 - m_idx];
            b = m_seq;
`ifdef SEQ_EXT_IN_EN
            if (bus.ext_sel) b = bus.seq_in;
`endif
            m_idx = (m_idx + 1) % 16;
            hist.push_back(b);
            if (hist.size() > 5) void'(hist.pop_front());
            if (m_since < 5) m_since++;
            hit = (m_since == 5) && (m_window() == m_det);
            if (hit && !bus.overlap) m_since = 0;
            m_match = hit;
            m_led = hit;
        end
        if (c) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        cmp("seq_out",    32'(bus.seq_out),    32'(m_seq));
        cmp("det_window", 32'(bus.det_window), 32'(m_window()));
        cmp("match",      32'(bus.match),      32'(m_match));
        cmp("match_led",  32'(bus.match_led),  32'(m_led));
        cmp("match_cnt",  32'(bus.match_cnt),  32'(m_cnt));
        cmp("match_cnt2", 32'(bus2.match_cnt), 32'(m_cnt2));
    endtask

    // Inputs change at the negedge; outputs are checked on the following negedge
    task automatic cycle(input logic t, input logic e, input logic l, input logic c);
        bus.tick = t; bus.enable = e; bus.load = l; bus.clear_cnt = c;
        @(posedge clk);
        @(negedge clk);
        m_apply(t, e, l, c);
        check();
    endtask

    typedef struct {
        logic       tick;
        logic       exp_seq;
        logic       exp_match;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t        tbl[16];
    logic [15:0] seq_ref;
    logic [4:0]  ext_bits;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        seq_ref = 16'b0111_0100_1101_1010;
        for (int i = 0; i < 16; i++) begin
            tbl[i].tick      = 1'b1;
            tbl[i].exp_seq   = seq_ref[15 - i];
            tbl[i].exp_match = (i == 6) || (i == 15);
            tbl[i].exp_cnt   = (i >= 15) ? 8'd2 : (i >= 6) ? 8'd1 : 8'd0;
        end

        bus.tick = 0; bus.enable = 1; bus.load = 0; bus.clear_cnt = 0;
        bus.overlap = 1; bus.gen_pattern = '0; bus.det_pattern = '0;
`ifdef SEQ_EXT_IN_EN
        bus.seq_in = 0; bus.ext_sel = 0;
`endif
        m_reset();
        repeat (2) @(negedge clk);
        check();
        rst_n = 1'b1;

        // Defaults: one full period from the table
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].tick, 1, 0, 0);
            cmp("t1_seq",   32'(bus.seq_out),   32'(tbl[i].exp_seq));
            cmp("t1_match", 32'(bus.match),     32'(tbl[i].exp_match));
            cmp("t1_cnt",   32'(bus.match_cnt), 32'(tbl[i].exp_cnt));
        end

        // Two more periods: no spurious hit across the wrap
        for (int i = 0; i < 32; i++) cycle(1, 1, 0, 0);
        cmp("t2_cnt48", 32'(bus.match_cnt), 32'd6);
        cycle(0, 1, 0, 1);
        cmp("t2_clear", 32'(bus.match_cnt), 32'd0);

        // AAAA / 10101, overlapping then non-overlapping
        bus.gen_pattern = 16'hAAAA; bus.det_pattern = 5'b10101; bus.overlap = 1;
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
        cmp("t3_ovl_cnt", 32'(bus.match_cnt), 32'd6);
        cmp("t4_sat_cnt", 32'(bus2.match_cnt), 32'd3);
        bus.overlap = 0;
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, 0);
            cmp("t3_nov_match", 32'(bus.match), 32'((i == 4) || (i == 10)));
        end
        cmp("t3_nov_cnt", 32'(bus.match_cnt), 32'd8);

        // Clear in the same cycle as a match wins
        bus.overlap = 1;
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cmp("t4_clr_match", 32'(bus.match), 32'd1);
        cmp("t4_clr_cnt",   32'(bus.match_cnt), 32'd0);
        cmp("t4_clr_cnt2",  32'(bus2.match_cnt), 32'd0);

        // Freeze with enable=0 while ticks keep coming, then resume
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);

        // Load coincident with a tick: tick dropped, next step emits the MSB
        bus.gen_pattern = 16'h8001; bus.det_pattern = 5'b00011;
        cycle(1, 1, 1, 0);
        cmp("t5_load_seq", 32'(bus.seq_out), 32'd0);
        cycle(1, 1, 0, 0);
        cmp("t5_first_msb", 32'(bus.seq_out), 32'd1);
        cycle(1, 1, 0, 0);
        cmp("t5_second", 32'(bus.seq_out), 32'd0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        bus.tick = 0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        m_reset();
        check();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
        cmp("t6_post_rst_cnt", 32'(bus.match_cnt), 32'd2);

`ifdef SEQ_EXT_IN_EN
        bus.gen_pattern = 16'h74DA; bus.det_pattern = 5'b11010;
        cycle(0, 1, 1, 0);
        bus.ext_sel = 1;
        ext_bits = 5'b11010;
        for (int i = 0; i < 5; i++) begin
            bus.seq_in = ext_bits[4 - i];
            cycle(1, 1, 0, 0);
        end
        cmp("t6_ext_match", 32'(bus.match), 32'd1);
        bus.ext_sel = 0; bus.seq_in = 0;
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic t, e, l, c;
            t = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) bus.overlap = $urandom_range(0, 1);
            if (l) begin
                bus.gen_pattern = 16'($urandom);
                bus.det_pattern = ($urandom_range(0, 1) != 0) ?
                                  bus.gen_pattern[$urandom_range(0, 11) +: 5] : 5'($urandom);
            end
`ifdef SEQ_EXT_IN_EN
            bus.ext_sel = ($urandom_range(0, 3) == 0);
            bus.seq_in  = $urandom_range(0, 1);
`endif
            cycle(t, e, l, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
